sweep_scheduler: RTL
====================

Name: sweep_scheduler

Overview:
- Parametrised control plane for the Pair-HMM systolic array.
- Sequences the anti-diagonal wavefront over a read of length R (rows) and a haplotype of length H (cols), using NUM_PE processing elements and ceil(R/NUM_PE) passes.
- Generates the PE enable/advance/sweep controls, the haplotype fetch handshake, and checkpoint read/write addressing. Checkpoint data and the PEs live outside this block.
- Unlike the previous controller, R and H are independent and NUM_PE/MAX_LEN are parameters. It adds a stallable fetch handshake, a parameter-error check and a result handshake.

Parameters:
NUM_PE, 4, number of processing elements in the array
MAX_LEN, 64, maximum R and H
LEN_W, $clog2(MAX_LEN+1), width of length inputs and index outputs

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  begin a job; sampled only in IDLE
read_len  in  LEN_W  R, latched on accepted start
hap_len  in  LEN_W  H, latched on accepted start
ref_req  out  1  request haplotype base ref_index
ref_index  out  LEN_W  haplotype column being fetched
ref_valid  in  1  requested base present this cycle
pe_done  in  NUM_PE  per-PE completion of current cell
pe_enable  out  NUM_PE  registered; bit i enables PE i
advance  out  1  one-cycle pulse: all PEs shift
sweep  out  1  one-cycle pulse: PEs clear between passes
row_base  out  LEN_W  first read row of current pass
ckpt_rd_en  out  1  read checkpoint entry for PE0
ckpt_rd_addr  out  LEN_W  checkpoint column read
ckpt_wr_en  out  1  store last-active-PE output
ckpt_wr_addr  out  LEN_W  checkpoint column written
busy  out  1  job in progress
param_err  out  1  one-cycle pulse: start rejected
result_valid  out  1  final-row PE holds the result
result_pe  out  $clog2(NUM_PE)  index of that PE
result_ack  in  1  consumer took the result
done  out  1  one-cycle pulse on result_ack

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE; all outputs 0; internal counters 0. This applies in any state, including mid-pass.
- Definitions:
  - active = min(NUM_PE, R - row_base).
  - At step k (0-based), PE i is enabled iff i < active and 0 <= k-i < H.
  - A pass has steps_total = H + active - 1 steps.
  - The final pass is the one where row_base + NUM_PE >= R.
- IDLE:
  - start with R==0, H==0, R>MAX_LEN or H>MAX_LEN: param_err=1 for one cycle; stay in IDLE.
  - Otherwise: latch R and H, row_base=0, k=0, busy=1, go to FETCH.
- FETCH:
  - If k < H: ref_req=1 and ref_index=k, both held stable until ref_valid.
  - If also row_base > 0: ckpt_rd_en=1 and ckpt_rd_addr=k for exactly the cycle in which ref_valid is seen.
  - On ref_valid, or immediately if k >= H: load pe_enable from the rule above and go to COMPUTE.
- COMPUTE:
  - Wait until (pe_done & pe_enable) == pe_enable.
  - In that cycle:
    - advance=1.
    - If this is not the final pass and pe_enable[active-1]: ckpt_wr_en=1, ckpt_wr_addr = k-(active-1).
  - Next state:
    - k < steps_total-1: k++, go to FETCH.
    - Otherwise, final pass: go to FINISH.
    - Otherwise: go to SWEEP.
- SWEEP (one cycle): sweep=1, pe_enable=0, row_base += NUM_PE, k=0, go to FETCH.
- FINISH:
  - pe_enable=0; result_valid=1; result_pe = active-1.
  - Both are held until result_ack. Then done=1 for one cycle, busy=0, go to IDLE.
- Fixed rules:
  - start is ignored while busy.
  - advance, sweep, ckpt_wr_en and ckpt_rd_en are never asserted in the same cycle as each other, except ckpt_wr_en together with advance.
  - Per step, the minimum is 2 cycles (FETCH + COMPUTE). There are no idle cycles when ref_valid and pe_done are tied high.
- Widths:
  - All index arithmetic is unsigned at LEN_W+1 bits.
  - steps_total never exceeds MAX_LEN + NUM_PE - 1.

Test Plan:
1. NUM_PE=4, R=4, H=3, ref_valid=1, pe_done=all 1 -> pe_enable (PE3..PE0) sequence 0001, 0011, 0111, 1110, 1100, 1000; 6 advance pulses; no sweep and no ckpt activity; result_pe=3.
2. R=6, H=2, handshakes tied high -> pass 0: 5 steps, ckpt_wr_addr 0 then 1. Then one sweep with row_base=4. Pass 1: pe_enable 0001, 0011, 0010; ckpt_rd_addr 0, 1; no ckpt_wr; result_pe=1.
3. R=4, H=3, ref_valid held low 5 cycles at k=1 -> ref_req stays 1, ref_index stays 1, and there is no advance until ref_valid rises.
4. At pe_enable 0011 with only pe_done[0]=1 for 3 cycles -> no advance. advance fires in the cycle pe_done[1] rises.
5. start with read_len=0 -> param_err pulse, busy=0. start with R=MAX_LEN+1 -> same. start during busy -> ignored.
6. reset=0 during pass 1 of test 2 -> the next cycle has all outputs 0 and state IDLE. A new start then repeats test 1 exactly.

Source files
------------

// File: rtl/sweep_scheduler_if.sv
// ---------------------------------------------------------------------------
// sweep_scheduler_if
//   Bundles the job, haplotype-fetch, PE-control, checkpoint and result
//   signals of the Pair-HMM sweep scheduler.
//
//   slave  modport : the scheduler itself
//   master modport : the surrounding datapath / environment
//
//   start, read_len, hap_len      job request (R, H)
//   ref_req, ref_index, ref_valid haplotype base fetch handshake
//   pe_done, pe_enable            per-PE completion / enable
//   advance, sweep, row_base      array shift, inter-pass clear, pass origin
//   ckpt_rd_*, ckpt_wr_*          checkpoint column read / write
//   busy, param_err               job status, rejected start
//   result_valid/pe/ack, done     result handshake
// ---------------------------------------------------------------------------
interface sweep_scheduler_if #(
    parameter int NUM_PE = 4,
    parameter int LEN_W  = 7,
    parameter int PE_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
);
    logic              start;
    logic [LEN_W-1:0]  read_len;
    logic [LEN_W-1:0]  hap_len;
    logic              ref_req;
    logic [LEN_W-1:0]  ref_index;
    logic              ref_valid;
    logic [NUM_PE-1:0] pe_done;
    logic [NUM_PE-1:0] pe_enable;
    logic              advance;
    logic              sweep;
    logic [LEN_W-1:0]  row_base;
    logic              ckpt_rd_en;
    logic [LEN_W-1:0]  ckpt_rd_addr;
    logic              ckpt_wr_en;
    logic [LEN_W-1:0]  ckpt_wr_addr;
    logic              busy;
    logic              param_err;
    logic              result_valid;
    logic [PE_W-1:0]   result_pe;
    logic              result_ack;
    logic              done;

    modport slave (
        input  start, read_len, hap_len, ref_valid, pe_done, result_ack,
        output ref_req, ref_index, pe_enable, advance, sweep, row_base,
               ckpt_rd_en, ckpt_rd_addr, ckpt_wr_en, ckpt_wr_addr,
               busy, param_err, result_valid, result_pe, done
    );

    modport master (
        output start, read_len, hap_len, ref_valid, pe_done, result_ack,
        input  ref_req, ref_index, pe_enable, advance, sweep, row_base,
               ckpt_rd_en, ckpt_rd_addr, ckpt_wr_en, ckpt_wr_addr,
               busy, param_err, result_valid, result_pe, done
    );
endinterface

// File: rtl/sweep_scheduler.sv
// ---------------------------------------------------------------------------
// sweep_scheduler
//   Control plane for the Pair-HMM systolic array. Walks the anti-diagonal
//   wavefront of an R x H matrix with NUM_PE PEs in ceil(R/NUM_PE) passes,
//   fetching one haplotype base per step and spilling / reloading the
//   boundary row through the checkpoint store between passes.
//
//   clock  : system clock
//   reset  : synchronous, active-low
//   bus    : sweep_scheduler_if.slave (job, fetch, PE, checkpoint, result)
// ---------------------------------------------------------------------------
module sweep_scheduler #(
    parameter int NUM_PE  = 4,
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                clock,
    input  logic                reset,
    sweep_scheduler_if.slave    bus
);
    localparam int IW   = LEN_W + 1;
    localparam int PE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    localparam logic [IW-1:0] NPE  = IW'(NUM_PE);
    localparam logic [IW-1:0] MAXL = IW'(MAX_LEN);
    localparam logic [IW-1:0] ONE  = IW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_COMPUTE,
        S_SWEEP,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     r_q, r_d;
    logic [IW-1:0]     h_q, h_d;
    logic [IW-1:0]     k_q, k_d;
    logic [IW-1:0]     row_base_q, row_base_d;
    logic [NUM_PE-1:0] pe_enable_q, pe_enable_d;

    // Pass geometry
    logic [IW-1:0]     rows_left;
    logic [IW-1:0]     active;
    logic [IW-1:0]     active_m1;
    logic [IW-1:0]     steps_last;
    logic              final_pass;
    logic [NUM_PE-1:0] step_en;
    logic              last_en;
    logic              all_done;
    logic [IW-1:0]     rl_in, hl_in;
    logic              bad_params;

    // Combinational outputs
    logic              ref_req_c;
    logic [LEN_W-1:0]  ref_index_c;
    logic              advance_c;
    logic              sweep_c;
    logic              ckpt_rd_en_c;
    logic [LEN_W-1:0]  ckpt_rd_addr_c;
    logic              ckpt_wr_en_c;
    logic [LEN_W-1:0]  ckpt_wr_addr_c;
    logic              param_err_c;
    logic              result_valid_c;
    logic [PE_W-1:0]   result_pe_c;
    logic              done_c;

    always_comb begin
        rows_left  = r_q - row_base_q;
        active     = (rows_left < NPE) ? rows_left : NPE;
        active_m1  = active - ONE;
        // steps_total - 1; H >= 1 and active >= 1 whenever this is used
        steps_last = h_q + active - ONE - ONE;
        final_pass = (row_base_q + NPE) >= r_q;
        all_done   = (bus.pe_done & pe_enable_q) == pe_enable_q;
        rl_in      = IW'(bus.read_len);
        hl_in      = IW'(bus.hap_len);
        bad_params = (rl_in == '0) || (hl_in == '0) ||
                     (rl_in > MAXL) || (hl_in > MAXL);
    end

    // PE i works on cell (row_base + i, k - i) at step k
    always_comb begin
        step_en = '0;
        last_en = 1'b0;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            step_en[i] = (IW'(i) < active) && (k_q >= IW'(i)) &&
                         ((k_q - IW'(i)) < h_q);
            if (IW'(i) == active_m1) begin
                last_en = pe_enable_q[i];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        r_d            = r_q;
        h_d            = h_q;
        k_d            = k_q;
        row_base_d     = row_base_q;
        pe_enable_d    = pe_enable_q;
        ref_req_c      = 1'b0;
        ref_index_c    = '0;
        advance_c      = 1'b0;
        sweep_c        = 1'b0;
        ckpt_rd_en_c   = 1'b0;
        ckpt_rd_addr_c = '0;
        ckpt_wr_en_c   = 1'b0;
        ckpt_wr_addr_c = '0;
        param_err_c    = 1'b0;
        result_valid_c = 1'b0;
        result_pe_c    = '0;
        done_c         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bad_params) begin
                        param_err_c = 1'b1;
                    end else begin
                        r_d         = rl_in;
                        h_d         = hl_in;
                        row_base_d  = '0;
                        k_d         = '0;
                        pe_enable_d = '0;
                        state_d     = S_FETCH;
                    end
                end
            end

            S_FETCH: begin
                if (k_q < h_q) begin
                    ref_req_c   = 1'b1;
                    ref_index_c = LEN_W'(k_q);
                    if (bus.ref_valid) begin
                        // pass 0 has no previous pass to reload from
                        if (row_base_q != '0) begin
                            ckpt_rd_en_c   = 1'b1;
                            ckpt_rd_addr_c = LEN_W'(k_q);
                        end
                        pe_enable_d = step_en;
                        state_d     = S_COMPUTE;
                    end
                end else begin
                    // drain steps: no new column to fetch
                    pe_enable_d = step_en;
                    state_d     = S_COMPUTE;
                end
            end

            S_COMPUTE: begin
                if (all_done) begin
                    advance_c = 1'b1;
                    if (!final_pass && last_en) begin
                        ckpt_wr_en_c   = 1'b1;
                        ckpt_wr_addr_c = LEN_W'(k_q - active_m1);
                    end
                    if (k_q < steps_last) begin
                        k_d     = k_q + ONE;
                        state_d = S_FETCH;
                    end else if (final_pass) begin
                        pe_enable_d = '0;
                        state_d     = S_FINISH;
                    end else begin
                        pe_enable_d = '0;
                        state_d     = S_SWEEP;
                    end
                end
            end

            S_SWEEP: begin
                sweep_c    = 1'b1;
                row_base_d = row_base_q + NPE;
                k_d        = '0;
                state_d    = S_FETCH;
            end

            S_FINISH: begin
                result_valid_c = 1'b1;
                result_pe_c    = PE_W'(active_m1);
                if (bus.result_ack) begin
                    done_c     = 1'b1;
                    row_base_d = '0;
                    k_d        = '0;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            h_q         <= '0;
            k_q         <= '0;
            row_base_q  <= '0;
            pe_enable_q <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            h_q         <= h_d;
            k_q         <= k_d;
            row_base_q  <= row_base_d;
            pe_enable_q <= pe_enable_d;
        end
    end

    assign bus.ref_req      = ref_req_c;
    assign bus.ref_index    = ref_index_c;
    assign bus.pe_enable    = pe_enable_q;
    assign bus.advance      = advance_c;
    assign bus.sweep        = sweep_c;
    assign bus.row_base     = LEN_W'(row_base_q);
    assign bus.ckpt_rd_en   = ckpt_rd_en_c;
    assign bus.ckpt_rd_addr = ckpt_rd_addr_c;
    assign bus.ckpt_wr_en   = ckpt_wr_en_c;
    assign bus.ckpt_wr_addr = ckpt_wr_addr_c;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.param_err    = param_err_c;
    assign bus.result_valid = result_valid_c;
    assign bus.result_pe    = result_pe_c;
    assign bus.done         = done_c;

endmodule
